// File: rtl/lsu_writeback.sv
`default_nettype none
// ============================================================================
// Module      : lsu_writeback
// Description : RV32I load/store unit: issues one memory command per request
//               and writes extended load data back to the register file.
//               Optional macro LSU_MISALIGN_TRAP_EN adds the misalign output.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_writeback #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_store,
    input  logic [2:0]   req_funct3,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    input  logic [4:0]   req_rd,
    output logic         mem_valid,
    input  logic         mem_ready,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    output logic [3:0]   mem_wstrb,
    input  logic         mem_rvalid,
    input  logic [N-1:0] mem_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic         misalign,
`endif
    output logic         RegWrite,
    output logic [4:0]   WriteReg,
    output logic [N-1:0] WriteData,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [1:0] c_SZ_BYTE = 2'd0;
    localparam logic [1:0] c_SZ_HALF = 2'd1;
    localparam logic [1:0] c_SZ_WORD = 2'd2;

    // Stores only know 000/001/010, so 100/101 fall back to word there;
    // every encoding not named by RV32I is handled as a word access.
    function automatic logic [1:0] accessSize(input logic store, input logic [2:0] f3);
        logic [1:0] sz;
        sz = c_SZ_WORD;
        if (store) begin
            if (f3 == 3'b000)      sz = c_SZ_BYTE;
            else if (f3 == 3'b001) sz = c_SZ_HALF;
        end else begin
            if (f3[1:0] == 2'b00)      sz = c_SZ_BYTE;
            else if (f3[1:0] == 2'b01) sz = c_SZ_HALF;
        end
        return sz;
    endfunction

    state_t         r_state;
    state_t         w_nextState;
    logic [N-1:0]   r_addr;
    logic [2:0]     r_funct3;
    logic           r_store;
    logic [4:0]     r_rd;
    logic [N-1:0]   r_wdata;
    logic [N-1:0]   r_rdata;
    logic           w_accept;
    logic           w_misalignReq;
    logic [1:0]     w_size;
    logic [7:0]     w_byte;
    logic [15:0]    w_half;
    logic [N-1:0]   w_loadValue;
    logic           w_regWrite;

    assign w_accept = req_valid && (r_state == IDLE);
    assign w_size   = accessSize(r_store, r_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_misalign;

    always_comb begin
        w_misalignReq = 1'b0;
        case (accessSize(req_store, req_funct3))
            c_SZ_HALF: w_misalignReq = req_addr[0];
            c_SZ_WORD: w_misalignReq = (req_addr[1:0] != 2'b00);
            default:   w_misalignReq = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_misalign <= 1'b0;
        else if (w_accept) r_misalign <= w_misalignReq;
    end

    assign misalign = (r_state == WB) && r_misalign;
`else
    logic r_misalign;
    assign w_misalignReq = 1'b0;
    assign r_misalign    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_funct3 <= '0;
            r_store  <= 1'b0;
            r_rd     <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_accept) begin
                r_addr   <= req_addr;
                r_funct3 <= req_funct3;
                r_store  <= req_store;
                r_rd     <= req_rd;
                r_wdata  <= req_wdata;
            end
            if (r_state == WAIT && mem_rvalid) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_byte = r_rdata[7:0];
        case (r_addr[1:0])
            2'd0:    w_byte = r_rdata[7:0];
            2'd1:    w_byte = r_rdata[15:8];
            2'd2:    w_byte = r_rdata[23:16];
            default: w_byte = r_rdata[31:24];
        endcase
        w_half = r_addr[1] ? r_rdata[31:16] : r_rdata[15:0];

        // funct3[2] marks the unsigned load variants
        case (w_size)
            c_SZ_BYTE: w_loadValue = {{(N-8){w_byte[7] & ~r_funct3[2]}}, w_byte};
            c_SZ_HALF: w_loadValue = {{(N-16){w_half[15] & ~r_funct3[2]}}, w_half};
            default:   w_loadValue = r_rdata;
        endcase
    end

    assign w_regWrite = (r_state == WB) && !r_store && (r_rd != 5'd0) && !r_misalign;

    always_comb begin
        w_nextState = r_state;
        req_ready   = 1'b0;
        mem_valid   = 1'b0;
        mem_we      = 1'b0;
        busy        = 1'b1;
        mem_addr    = {r_addr[N-1:2], 2'b00};
        mem_wstrb   = 4'b0000;
        mem_wdata   = r_wdata;
        RegWrite    = w_regWrite;
        WriteReg    = w_regWrite ? r_rd : 5'd0;
        WriteData   = w_regWrite ? w_loadValue : '0;

        if (r_store) begin
            case (w_size)
                c_SZ_BYTE: begin
                    mem_wstrb = 4'b0001 << r_addr[1:0];
                    mem_wdata = {4{r_wdata[7:0]}};
                end
                c_SZ_HALF: begin
                    mem_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{r_wdata[15:0]}};
                end
                default: begin
                    mem_wstrb = 4'b1111;
                    mem_wdata = r_wdata;
                end
            endcase
        end

        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    w_nextState = w_misalignReq ? WB : REQ;
                end
            end
            REQ: begin
                mem_valid = 1'b1;
                mem_we    = r_store;
                if (mem_ready) begin
                    w_nextState = r_store ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    w_nextState = WB;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_writeback
// Description : Directed-vector testbench for lsu_writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_writeback;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        busy;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int nChecks = 0;
    int nPassed = 0;

    lsu_writeback #(.N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign   (misalign),
`endif
        .RegWrite   (RegWrite),
        .WriteReg   (WriteReg),
        .WriteData  (WriteData),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            nPassed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one accept edge, then scramble the live inputs
    // so any output that tracks them instead of the captured copy shows up.
    task automatic issue(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        req_valid  = 1'b1;
        req_store  = store;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        tick();
        req_valid  = 1'b0;
        req_store  = ~store;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h5555_5555;
        req_rd     = 5'd31;
    endtask

    task automatic doLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input logic expWe, input logic [31:0] expData);
        issue(1'b0, f3, addr, 32'h0, rd);
        checkValue({tag, ".mem_valid"}, {31'd0, mem_valid}, 32'd1);
        checkValue({tag, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        checkValue({tag, ".mem_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
        checkValue({tag, ".mem_we"}, {31'd0, mem_we}, 32'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        checkValue({tag, ".wait_regwrite"}, {31'd0, RegWrite}, 32'd0);
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        checkValue({tag, ".RegWrite"}, {31'd0, RegWrite}, {31'd0, expWe});
        checkValue({tag, ".WriteReg"}, {27'd0, WriteReg}, expWe ? {27'd0, rd} : 32'd0);
        checkValue({tag, ".WriteData"}, WriteData, expData);
        tick();
        checkValue({tag, ".after_regwrite"}, {31'd0, RegWrite}, 32'd0);
        checkValue({tag, ".after_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic doStore(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] expStrb,
                           input logic [31:0] expWdata);
        issue(1'b1, f3, addr, wdata, 5'd3);
        checkValue({tag, ".mem_valid"}, {31'd0, mem_valid}, 32'd1);
        checkValue({tag, ".mem_we"}, {31'd0, mem_we}, 32'd1);
        checkValue({tag, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        checkValue({tag, ".mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, expStrb});
        checkValue({tag, ".mem_wdata"}, mem_wdata, expWdata);
        checkValue({tag, ".req_ready"}, {31'd0, req_ready}, 32'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checkValue({tag, ".busy"}, {31'd0, busy}, 32'd0);
        checkValue({tag, ".RegWrite"}, {31'd0, RegWrite}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_rd     = 5'd0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        tick();
        tick();
        checkValue("rst.req_ready", {31'd0, req_ready}, 32'd1);
        checkValue("rst.busy", {31'd0, busy}, 32'd0);
        checkValue("rst.mem_valid", {31'd0, mem_valid}, 32'd0);
        checkValue("rst.mem_we", {31'd0, mem_we}, 32'd0);
        checkValue("rst.mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        checkValue("rst.mem_addr", mem_addr, 32'd0);
        checkValue("rst.mem_wdata", mem_wdata, 32'd0);
        checkValue("rst.RegWrite", {31'd0, RegWrite}, 32'd0);
        checkValue("rst.WriteData", WriteData, 32'd0);
        rst = 1'b0;
        tick();

        doLoad("lw",  3'b010, 32'h100, 5'd5,  32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
        doLoad("lb",  3'b000, 32'h103, 5'd6,  32'h80112233, 1'b1, 32'hFFFFFF80);
        doLoad("lbu", 3'b100, 32'h103, 5'd6,  32'h80112233, 1'b1, 32'h00000080);
        doLoad("lh",  3'b001, 32'h102, 5'd8,  32'h80112233, 1'b1, 32'hFFFF8011);
        doLoad("lhu", 3'b101, 32'h102, 5'd8,  32'h80112233, 1'b1, 32'h00008011);
        doLoad("lb0", 3'b000, 32'h100, 5'd9,  32'h80112233, 1'b1, 32'h00000033);
        doLoad("lh0", 3'b001, 32'h100, 5'd10, 32'h1234F00D, 1'b1, 32'hFFFFF00D);
        doLoad("lwr", 3'b111, 32'h104, 5'd11, 32'hA5A5C3C3, 1'b1, 32'hA5A5C3C3);
        doLoad("rd0", 3'b010, 32'h100, 5'd0,  32'hDEADBEEF, 1'b0, 32'h0);

        doStore("sh",  3'b001, 32'h206, 32'h0000ABCD, 4'b1100, 32'hABCDABCD);
        doStore("sb",  3'b000, 32'h101, 32'h123456A5, 4'b0010, 32'hA5A5A5A5);
        doStore("sw",  3'b010, 32'h10C, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
        doStore("swr", 3'b011, 32'h010, 32'h01234567, 4'b1111, 32'h01234567);

        // Memory back-pressure on both the command and the read response
        issue(1'b0, 3'b010, 32'h300, 32'h0, 5'd7);
        for (int i = 0; i < 3; i++) begin
            checkValue("stall.mem_valid", {31'd0, mem_valid}, 32'd1);
            checkValue("stall.mem_addr", mem_addr, 32'h300);
            tick();
        end
        checkValue("stall.mem_valid_end", {31'd0, mem_valid}, 32'd1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkValue("stall.wait_busy", {31'd0, busy}, 32'd1);
            checkValue("stall.wait_regwrite", {31'd0, RegWrite}, 32'd0);
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        tick();
        mem_rvalid = 1'b0;
        checkValue("stall.RegWrite", {31'd0, RegWrite}, 32'd1);
        checkValue("stall.WriteData", WriteData, 32'h12345678);
        tick();
        checkValue("stall.single_pulse", {31'd0, RegWrite}, 32'd0);
        mem_rvalid = 1'b1;
        mem_ready  = 1'b1;
        tick();
        checkValue("idle_spurious.busy", {31'd0, busy}, 32'd0);
        checkValue("idle_spurious.RegWrite", {31'd0, RegWrite}, 32'd0);
        mem_rvalid = 1'b0;
        mem_ready  = 1'b0;
        tick();

        // Reset while waiting for read data, then a stale response
        issue(1'b0, 3'b010, 32'h400, 32'h0, 5'd9);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checkValue("rstwait.busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #2;
        checkValue("rstwait.busy", {31'd0, busy}, 32'd0);
        checkValue("rstwait.req_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0BAD0;
        tick();
        checkValue("rstwait.RegWrite", {31'd0, RegWrite}, 32'd0);
        checkValue("rstwait.busy_after", {31'd0, busy}, 32'd0);
        tick();
        checkValue("rstwait.RegWrite2", {31'd0, RegWrite}, 32'd0);
        mem_rvalid = 1'b0;

`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 32'h101, 32'h0, 5'd4);
        checkValue("mis.mem_valid", {31'd0, mem_valid}, 32'd0);
        checkValue("mis.misalign", {31'd0, misalign}, 32'd1);
        checkValue("mis.RegWrite", {31'd0, RegWrite}, 32'd0);
        checkValue("mis.busy", {31'd0, busy}, 32'd1);
        tick();
        checkValue("mis.misalign_clr", {31'd0, misalign}, 32'd0);
        checkValue("mis.mem_valid2", {31'd0, mem_valid}, 32'd0);
        checkValue("mis.busy2", {31'd0, busy}, 32'd0);
`endif

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
